// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - Synchronous-write, bypassed-read register file with pending-write scoreboard
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [AW-1:0]           rs1,
    input  logic [AW-1:0]           rs2,
    input  logic [AW-1:0]           rd,
    input  logic                    use1,
    input  logic                    use2,
    input  logic                    issue,
    input  logic                    issue_wr,
    input  logic                    flush,
    input  logic                    write,
    input  logic [AW-1:0]           wd,
    input  logic signed [XLEN-1:0]  wdata,
    output logic signed [XLEN-1:0]  data1,
    output logic signed [XLEN-1:0]  data2,
    output logic                    stall,
    output logic [NREGS-1:0]        busy
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_next;

    logic wr_en;
    logic byp1;
    logic byp2;
    logic byp_rd;
    logic hit1;
    logic hit2;
    logic waw;
    logic accept;

    // Writes to x0 are dropped so the zero register never changes
    assign wr_en  = write && (wd != '0);

    // A writeback aimed at the index being read satisfies the read this cycle
    assign byp1   = write && (wd == rs1);
    assign byp2   = write && (wd == rs2);
    assign byp_rd = write && (wd == rd);

    // Operand read: x0 forced to zero, then same-cycle bypass, then the array
    always_comb begin
        data1 = '0;
        data2 = '0;
        if (rs1 != '0) begin
            data1 = byp1 ? wdata : $signed(regs[rs1]);
        end
        if (rs2 != '0) begin
            data2 = byp2 ? wdata : $signed(regs[rs2]);
        end
    end

    // Hazard detection: RAW on either used source, WAW on the destination;
    // a retiring write to the same register already resolves the hazard
    always_comb begin
        hit1   = use1 && busy_q[rs1] && !byp1;
        hit2   = use2 && busy_q[rs2] && !byp2;
        waw    = issue_wr && (rd != '0) && busy_q[rd] && !byp_rd;
        stall  = issue && !flush && (hit1 || hit2 || waw);
        accept = issue && !stall && !flush;
    end

    // Next pending vector: flush wipes everything, otherwise clear on retire
    // then set on accept so a new claim outlives a same-cycle retire
    always_comb begin
        busy_next = busy_q;
        if (flush) begin
            busy_next = '0;
        end else begin
            if (wr_en) begin
                busy_next[wd] = 1'b0;
            end
            if (accept && issue_wr && (rd != '0)) begin
                busy_next[rd] = 1'b1;
            end
        end
    end

    // Scoreboard state; bit 0 can never be set because rd==0 is excluded
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    // Register array; reset discards any writeback on the same edge,
    // while flush does not stop an in-flight write from committing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wd] <= wdata;
        end
    end

    assign busy = {busy_q[NREGS-1:1], 1'b0};

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - Table-driven self-checking bench for regfile_sb
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   rs1, rs2, rd, wd;
    logic            use1, use2, issue, issue_wr, flush, write;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] data1, data2;
    logic            stall;
    logic [NREGS-1:0] busy;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rd(rd),
        .use1(use1), .use2(use2), .issue(issue), .issue_wr(issue_wr),
        .flush(flush), .write(write), .wd(wd), .wdata(wdata),
        .data1(data1), .data2(data2), .stall(stall), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            rst_n;
        logic            issue;
        logic            issue_wr;
        logic [AW-1:0]   rd;
        logic            use1;
        logic [AW-1:0]   rs1;
        logic            use2;
        logic [AW-1:0]   rs2;
        logic            flush;
        logic            write;
        logic [AW-1:0]   wd;
        logic [XLEN-1:0] wdata;
        logic [XLEN-1:0] exp_d1;
        logic [XLEN-1:0] exp_d2;
        logic            exp_stall;
        logic [NREGS-1:0] exp_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(
        logic r, logic iss, logic iwr, int d, logic u1, int s1, logic u2, int s2,
        logic fl, logic wr, int w, logic [XLEN-1:0] wv,
        logic [XLEN-1:0] e1, logic [XLEN-1:0] e2, logic est, logic [NREGS-1:0] eb);
        vec_t t;
        t.rst_n = r;   t.issue = iss; t.issue_wr = iwr; t.rd = AW'(d);
        t.use1 = u1;   t.rs1 = AW'(s1); t.use2 = u2;    t.rs2 = AW'(s2);
        t.flush = fl;  t.write = wr;  t.wd = AW'(w);    t.wdata = wv;
        t.exp_d1 = e1; t.exp_d2 = e2; t.exp_stall = est; t.exp_busy = eb;
        return t;
    endfunction

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        rst_n = 1'b1; issue = 1'b0; issue_wr = 1'b0; rd = '0; use1 = 1'b0; rs1 = '0;
        use2 = 1'b0; rs2 = '0; flush = 1'b0; write = 1'b0; wd = '0; wdata = '0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #3;

        // Reset state: nothing pending, no stall, every register reads zero
        chk("rst_busy", XLEN'(busy), 32'h0);
        chk("rst_stall", XLEN'(stall), 32'h0);
        for (int i = 0; i < NREGS; i++) begin
            rs1 = AW'(i);
            rs2 = AW'(NREGS - 1 - i);
            #1;
            chk($sformatf("rst_x%0d", i), data1, 32'h0);
            chk($sformatf("rst_x%0d_p2", NREGS - 1 - i), data2, 32'h0);
        end
        rs1 = '0; rs2 = '0;
        @(posedge clk);
        #1;

        //          rst iss iwr rd u1 rs1 u2 rs2 fl wr wd wdata         d1            d2            st busy-after
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 32'h0,        32'h0,        0, 32'h0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h0));
        tbl.push_back(v(1, 0, 0, 0, 0, 5, 0, 0, 0, 1, 5, 32'h12345678, 32'h12345678, 32'h0,        0, 32'h0));
        tbl.push_back(v(1, 0, 0, 0, 0, 5, 0, 5, 0, 0, 0, 32'h0,        32'h12345678, 32'h12345678, 0, 32'h0));
        tbl.push_back(v(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h80));
        tbl.push_back(v(1, 1, 0, 0, 1, 7, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h80));
        tbl.push_back(v(1, 1, 0, 0, 1, 7, 0, 0, 0, 1, 7, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h0,        0, 32'h0));
        tbl.push_back(v(1, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 32'h0,        32'hFFFFFFFD, 32'h0,        0, 32'h0));
        tbl.push_back(v(1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h200));
        tbl.push_back(v(1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h200));
        tbl.push_back(v(1, 1, 1, 9, 0, 0, 0, 9, 0, 1, 9, 32'h99,       32'h0,        32'h99,       0, 32'h200));
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 32'h0,        32'h0,        32'h99,       1, 32'h200));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 9, 0, 1, 9, 32'hAA,       32'h0,        32'hAA,       0, 32'h0));
        tbl.push_back(v(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h8));
        tbl.push_back(v(1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h18));
        tbl.push_back(v(1, 1, 1, 6, 1, 3, 0, 0, 1, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h0));
        tbl.push_back(v(1, 0, 0, 0, 0, 3, 0, 0, 0, 1, 3, 32'h55,       32'h55,       32'h0,        0, 32'h0));
        tbl.push_back(v(1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 32'h0,        32'h55,       32'h0,        0, 32'h0));
        tbl.push_back(v(1, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h0,        32'h0,        0, 32'h400));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 11, 32'h1111,    32'h0,        32'h0,        0, 32'h0));
        tbl.push_back(v(1, 0, 0, 0, 0, 11, 0, 0, 0, 0, 0, 32'h0,       32'h1111,     32'h0,        0, 32'h0));
        tbl.push_back(v(1, 1, 1, 12, 0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h0,        32'h0,        0, 32'h1000));
        tbl.push_back(v(0, 0, 0, 0, 0, 12, 0, 0, 0, 1, 12, 32'h77,     32'h77,       32'h0,        0, 32'h0));
        tbl.push_back(v(1, 0, 0, 0, 0, 12, 0, 5, 0, 0, 0, 32'h0,       32'h0,        32'h0,        0, 32'h0));
        tbl.push_back(v(1, 0, 0, 0, 0, 3, 0, 11, 0, 0, 0, 32'h0,       32'h0,        32'h0,        0, 32'h0));
        tbl.push_back(v(1, 1, 1, 13, 0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h0,        32'h0,        0, 32'h2000));
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 1, 13, 0, 1, 14, 32'h1,      32'h0,        32'h0,        1, 32'h2000));
        tbl.push_back(v(1, 1, 0, 0, 0, 13, 0, 0, 0, 0, 0, 32'h0,       32'h0,        32'h0,        0, 32'h2000));
        tbl.push_back(v(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h2000));
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 1, 14, 0, 0, 0, 32'h0,       32'h0,        32'h1,        0, 32'h2000));

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n; issue = tbl[i].issue; issue_wr = tbl[i].issue_wr;
            rd = tbl[i].rd; use1 = tbl[i].use1; rs1 = tbl[i].rs1;
            use2 = tbl[i].use2; rs2 = tbl[i].rs2; flush = tbl[i].flush;
            write = tbl[i].write; wd = tbl[i].wd; wdata = tbl[i].wdata;
            #3;
            chk($sformatf("v%0d_data1", i), data1, tbl[i].exp_d1);
            chk($sformatf("v%0d_data2", i), data2, tbl[i].exp_d2);
            chk($sformatf("v%0d_stall", i), XLEN'(stall), XLEN'(tbl[i].exp_stall));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_busy", i), XLEN'(busy), XLEN'(tbl[i].exp_busy));
        end

        // Full sweep: write every register, then read all back on both ports
        idle();
        for (int i = 0; i < NREGS; i++) begin
            write = 1'b1; wd = AW'(i); wdata = 32'h01010101 * i + 32'hA0000000;
            @(posedge clk);
            #1;
        end
        idle();
        for (int i = 0; i < NREGS; i++) begin
            rs1 = AW'(i);
            rs2 = AW'(i);
            #1;
            chk($sformatf("sweep_x%0d_d1", i), data1, (i == 0) ? 32'h0 : 32'h01010101 * i + 32'hA0000000);
            chk($sformatf("sweep_x%0d_d2", i), data2, (i == 0) ? 32'h0 : 32'h01010101 * i + 32'hA0000000);
        end

        // Stall held across several cycles until the writeback bypass releases it
        idle();
        issue = 1'b1; issue_wr = 1'b1; rd = AW'(20);
        @(posedge clk);
        #1;
        issue_wr = 1'b0; rd = '0; use1 = 1'b1; rs1 = AW'(20); use2 = 1'b1; rs2 = AW'(20);
        for (int c = 0; c < 3; c++) begin
            #2;
            chk($sformatf("hold_stall_c%0d", c), XLEN'(stall), 32'h1);
            @(posedge clk);
            #1;
            chk($sformatf("hold_busy_c%0d", c), XLEN'(busy), 32'h0010_0000);
        end
        write = 1'b1; wd = AW'(20); wdata = 32'h8000_0001;
        #2;
        chk("release_stall", XLEN'(stall), 32'h0);
        chk("release_d1", data1, 32'h8000_0001);
        chk("release_d2", data2, 32'h8000_0001);
        @(posedge clk);
        #1;
        chk("release_busy", XLEN'(busy), 32'h0);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Clocked, parametrised register file for the pipelined core, replacing the combinational register array with a synchronous-write, bypassed-read array plus a per-register pending-write scoreboard. It sits between decode and execute. Decode presents source and destination indices each cycle and receives operand data and a stall indication. Writeback retires results into the array and clears the matching scoreboard entries. Register 0 is hardwired to zero.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥ 2)
- AW, $clog2(NREGS), register index width (derived; not overridden)

- clk  input  1  core clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- rs1  input  AW  source 1 index
- rs2  input  AW  source 2 index
- rd  input  AW  destination index of instruction at decode
- use1  input  1  instruction reads rs1
- use2  input  1  instruction reads rs2
- issue  input  1  decode holds a valid instruction requesting issue
- issue_wr  input  1  issuing instruction will write rd
- flush  input  1  pipeline flush; clears all pending bits
- write  input  1  writeback strobe
- wd  input  AW  writeback destination index
- wdata  input  XLEN  writeback data (signed)
- data1  output  XLEN  rs1 operand (signed)
- data2  output  XLEN  rs2 operand (signed)
- stall  output  1  issue blocked this cycle
- busy  output  NREGS  pending-write vector; bit i set = write to register i outstanding

## Operation
- Array: NREGS × XLEN. Writes with write=1 and wd≠0 commit on the rising edge. Writes to register 0 are dropped.
- Reads are combinational.
  - data1 = 0 if rs1==0.
  - Otherwise data1 = wdata if write && wd==rs1 (same-cycle bypass).
  - Otherwise data1 = array[rs1].
  - data2 follows the same rules using rs2.
- Scoreboard: busy[0] is constant 0.
  - hit1 = use1 && busy[rs1] && !(write && wd==rs1)
  - hit2 = use2 && busy[rs2] && !(write && wd==rs2)
  - waw = issue_wr && rd≠0 && busy[rd] && !(write && wd==rd)
  - stall = issue && !flush && (hit1 || hit2 || waw)
- accept = issue && !stall && !flush.
- Busy update per edge, applied in priority order:
  1. rst_n=0 → all 0.
  2. flush → all 0. An in-flight write still commits its data.
  3. Otherwise, if write && wd≠0, clear busy[wd]. Then, if accept && issue_wr && rd≠0, set busy[rd]. A set wins over a clear on the same index.
- Signed values are stored and forwarded unmodified. There is no width conversion.

## Timing
- Reset: with rst_n low at an edge, every array entry and busy bit becomes 0 at that edge. After reset: data1=data2=0, busy=0, and stall=0 until a register is marked pending.
- Write latency: a write is visible through the bypass in the same cycle, and from the array from the next cycle on.
- Scoreboard latency: a busy bit set by accept at edge N first causes a stall in the cycle after edge N.
- A writeback in cycle N releases a stall in cycle N, because the bypass covers it.
- stall depends combinationally on the inputs. Decode holds rs1, rs2, rd, use*, issue_wr and issue stable while stall=1.
- Reset asserted mid-operation: any pending writeback on that edge is discarded. All state is zeroed.
- Simultaneous flush and issue: the issue is not accepted and stall=0. Decode is responsible for discarding the instruction.

## Test plan
- Reset/zero:
  - Drive write=1, wd=0, wdata=32'hDEADBEEF, then read rs1=0 → data1=0, busy[0]=0.
  - After reset, all registers read 0.
- Write/read/bypass:
  - Write x5=32'h1234_5678 → same cycle data1 (rs1=5) = 32'h12345678 via bypass.
  - Next cycle, with write=0, data1 is still 32'h12345678.
- RAW stall:
  - Issue rd=7, issue_wr=1 → busy[7]=1.
  - Next cycle issue use1=1, rs1=7 → stall=1.
  - Cycle with write=1, wd=7, wdata=-3 → stall=0, data1=32'hFFFFFFFD, and busy[7]=0 after the edge.
- WAW and set-over-clear:
  - While busy[9]=1, issue rd=9 → stall=1.
  - With write=1, wd=9 and a new issue rd=9 in the same cycle → accepted, and busy[9] stays 1.
- Flush:
  - Set busy[3] and busy[4], then assert flush with issue=1, rd=6 → busy=0 and stall=0, with bit 6 not set.
  - A later write to x3 = 32'h55 still reads 32'h55.
- Reset mid-operation:
  - With busy[12]=1, assert rst_n=0 on the same edge as write=1, wd=12, wdata=32'h77 → busy=0 and x12 reads 0.
